pockstat_timer_bank: RTL and testbench



---
 rtl/pockstat_timer_pkg.sv | 43 ++++
 rtl/pockstat_timer_chan.sv | 98 +++++++++
 rtl/pockstat_timer_bank.sv | 94 +++++++++
 tb/tb_pockstat_timer_bank.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pockstat_timer_pkg.sv
// Shared definitions for the PocketStation timer bank: register map, CTRL layout, prescaler dividers.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package pockstat_timer_pkg;

    // Word offsets of the four registers inside one channel's window
    localparam logic [1:0] REG_RELOAD = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_DIV_LSB = 1;
    localparam int CTRL_DIV_MSB = 2;
    localparam int CTRL_ONESHOT = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int CTRL_W       = 5;

    // STATUS register bit positions
    localparam int STATUS_PENDING = 0;

    // Prescaler counter width; wide enough for the largest divider (2048)
    localparam int PRESC_W = 11;

    typedef enum logic [1:0] {
        DIV_2    = 2'b00,
        DIV_32   = 2'b01,
        DIV_512  = 2'b10,
        DIV_2048 = 2'b11
    } div_sel_e;

    // Terminal prescaler value (divider - 1) at which a tick is produced
    function automatic logic [PRESC_W-1:0] div_terminal(input div_sel_e sel);
        case (sel)
            DIV_2:   return 11'd1;
            DIV_32:  return 11'd31;
            DIV_512: return 11'd511;
            default: return 11'd2047;
        endcase
    endfunction

endpackage

// File: rtl/pockstat_timer_chan.sv
// One timer channel: prescaler, down-counter with reload, CTRL fields and a sticky pending flag.
// Latency: register writes take effect on the next edge; pending rises on the underflow edge.
// Backpressure: none; writes are single-cycle strobes and are always accepted.
module pockstat_timer_chan
    import pockstat_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             wr_reload,
    input  logic             wr_count,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] reload,
    output logic [CNT_W-1:0] count,
    output logic [CTRL_W-1:0] ctrl,
    output logic             pending,
    output logic             irq
);

    logic                enable;
    div_sel_e            div_sel;
    logic                oneshot;
    logic                irq_en;
    logic [PRESC_W-1:0]  presc;
    logic                tick;
    logic                underflow;

    // A tick ends each prescaler period; a CPU COUNT write in that cycle overrides it
    assign tick      = ce && enable && (presc == div_terminal(div_sel));
    assign underflow = tick && !wr_count && (count == '0);

    // Prescaler: runs only while enabled on ce, restarts on any CTRL write
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (wr_ctrl) begin
            presc <= '0;
        end else if (ce && enable) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end
    end

    // RELOAD is only ever changed by the CPU; an underflow in the same cycle still sees the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            reload <= '0;
        end else if (wr_reload) begin
            reload <= wdata;
        end
    end

    // Down-counter: CPU write has priority over the tick
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wdata;
        end else if (tick) begin
            count <= (count == '0) ? reload : count - CNT_W'(1);
        end
    end

    // CTRL fields; a one-shot underflow drops enable unless the CPU rewrites CTRL that cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            enable  <= 1'b0;
            div_sel <= DIV_2;
            oneshot <= 1'b0;
            irq_en  <= 1'b0;
        end else if (wr_ctrl) begin
            enable  <= wdata[CTRL_ENABLE];
            div_sel <= div_sel_e'(wdata[CTRL_DIV_MSB:CTRL_DIV_LSB]);
            oneshot <= wdata[CTRL_ONESHOT];
            irq_en  <= wdata[CTRL_IRQ_EN];
        end else if (underflow && oneshot) begin
            enable  <= 1'b0;
        end
    end

    // Pending flag: set on underflow, write-1-to-clear; a simultaneous set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (underflow) begin
            pending <= 1'b1;
        end else if (wr_status && wdata[STATUS_PENDING]) begin
            pending <= 1'b0;
        end
    end

    assign ctrl = {irq_en, oneshot, div_sel, enable};
    assign irq  = pending && irq_en;

endmodule

// File: rtl/pockstat_timer_bank.sv
// Bank of NUM_TIMERS down-counting timers on the peripheral bus with per-channel maskable interrupts.
// Latency: read data returns with bus_rvalid one cycle after bus_rd; irq follows pending combinationally.
// Backpressure: none; every bus strobe is accepted in the cycle it is presented.
module pockstat_timer_bank
    import pockstat_timer_pkg::*;
#(
    parameter int NUM_TIMERS = 3,
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = $clog2(NUM_TIMERS) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic                  bus_wr,
    input  logic                  bus_rd,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic                  bus_rvalid,
    output logic [NUM_TIMERS-1:0] irq,
    output logic                  irq_any
);

    logic [31:0]       addr_ext;
    logic [29:0]       chan_idx;
    logic [1:0]        reg_sel;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    logic [CNT_W-1:0]  reload_q  [NUM_TIMERS];
    logic [CNT_W-1:0]  count_q   [NUM_TIMERS];
    logic [CTRL_W-1:0] ctrl_q    [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] pending_q;

    // Zero-extend so the channel field decodes uniformly, including a single-channel bank
    assign addr_ext     = 32'(bus_addr);
    assign chan_idx     = addr_ext[31:2];
    assign reg_sel      = addr_ext[1:0];
    assign unused_wdata = ^bus_wdata;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        logic sel;
        assign sel = (chan_idx == 30'(i));

        pockstat_timer_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .wr_reload (bus_wr && sel && (reg_sel == REG_RELOAD)),
            .wr_count  (bus_wr && sel && (reg_sel == REG_COUNT)),
            .wr_ctrl   (bus_wr && sel && (reg_sel == REG_CTRL)),
            .wr_status (bus_wr && sel && (reg_sel == REG_STATUS)),
            .wdata     (bus_wdata[CNT_W-1:0]),
            .reload    (reload_q[i]),
            .count     (count_q[i]),
            .ctrl      (ctrl_q[i]),
            .pending   (pending_q[i]),
            .irq       (irq[i])
        );
    end

    // Read mux over pre-write register values; unmapped channels read as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (chan_idx == 30'(i)) begin
                case (reg_sel)
                    REG_RELOAD: rd_mux = 32'(reload_q[i]);
                    REG_COUNT:  rd_mux = 32'(count_q[i]);
                    REG_CTRL:   rd_mux = 32'(ctrl_q[i]);
                    default:    rd_mux = 32'(pending_q[i]);
                endcase
            end
        end
    end

    // Registered read port: capture on bus_rd, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            bus_rvalid <= bus_rd;
            if (bus_rd) begin
                bus_rdata <= rd_mux;
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_pockstat_timer_bank.sv
module tb_pockstat_timer_bank;

    localparam int NT     = 3;
    localparam int CW     = 32;
    localparam int ADDR_W = $clog2(NT) + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wr;
    logic              bus_rd;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_rvalid;
    logic [NT-1:0]     irq;
    logic              irq_any;

    pockstat_timer_bank #(
        .NUM_TIMERS (NT),
        .CNT_W      (CW),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .bus_addr   (bus_addr),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_on   = 0;

    // Behavioural model of the register file
    logic [31:0] m_reload [NT];
    logic [31:0] m_count  [NT];
    logic [1:0]  m_div    [NT];
    bit          m_en     [NT];
    bit          m_oneshot[NT];
    bit          m_irqen  [NT];
    bit          m_pend   [NT];
    int          m_phase  [NT];
    logic [NT-1:0] m_irq  = '0;
    bit          m_rvalid = 0;
    logic [31:0] m_rdata  = '0;

    // Directed reads may supply their expected value directly
    bit          ovr_vld = 0;
    logic [31:0] ovr     = '0;

    typedef struct {
        string       name;
        logic [31:0] dat;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 2;
            2'd1:    return 32;
            2'd2:    return 512;
            default: return 2048;
        endcase
    endfunction

    function automatic logic [31:0] model_val(input int c, input int r);
        case (r)
            0:       return m_reload[c];
            1:       return m_count[c];
            2:       return {27'b0, m_irqen[c], m_oneshot[c], m_div[c], m_en[c]};
            default: return {31'b0, m_pend[c]};
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge
    task automatic model_edge();
        int ch, r;
        bit hit, tick, here, cwr, uf;
        logic [31:0] v;
        if (reset) begin
            for (int c = 0; c < NT; c++) begin
                m_reload[c] = '0; m_count[c] = '0; m_div[c] = '0; m_en[c] = 0;
                m_oneshot[c] = 0; m_irqen[c] = 0; m_pend[c] = 0; m_phase[c] = 0;
            end
            m_irq = '0; m_rvalid = 0; m_rdata = '0;
            return;
        end
        ch  = int'(bus_addr) >> 2;
        r   = int'(bus_addr) & 3;
        hit = (ch < NT);
        if (bus_rd) begin
            v = hit ? model_val(ch, r) : 32'h0;
            if (ovr_vld) v = ovr;
            sb_q.push_back('{$sformatf("read ch%0d reg%0d", ch, r), v});
            m_rdata = v;
        end
        m_rvalid = bus_rd;
        for (int c = 0; c < NT; c++) begin
            tick = 0;
            if (ce && m_en[c]) begin
                m_phase[c] = (m_phase[c] + 1) % div_of(m_div[c]);
                tick = (m_phase[c] == 0);
            end
            here = bus_wr && hit && (ch == c);
            cwr  = here && (r == 1);
            uf   = tick && !cwr && (m_count[c] == 0);
            if (tick && !cwr) m_count[c] = (m_count[c] == 0) ? m_reload[c] : m_count[c] - 1;
            if (uf && m_oneshot[c]) m_en[c] = 0;
            if (here) begin
                case (r)
                    0: m_reload[c] = bus_wdata;
                    1: m_count[c]  = bus_wdata;
                    2: begin
                        m_en[c] = bus_wdata[0]; m_div[c] = bus_wdata[2:1];
                        m_oneshot[c] = bus_wdata[3]; m_irqen[c] = bus_wdata[4];
                        m_phase[c] = 0;
                    end
                    default: if (bus_wdata[0]) m_pend[c] = 0;
                endcase
            end
            if (uf) m_pend[c] = 1;
            m_irq[c] = m_pend[c] && m_irqen[c];
        end
    endtask

    // Monitor: pops expected read data whenever the DUT presents it, checks irq every cycle
    always @(negedge clk) begin
        if (mon_on) begin
            chk("rvalid", 32'(bus_rvalid), 32'(m_rvalid));
            if (bus_rvalid && sb_q.size() > 0) begin
                sb_e = sb_q.pop_front();
                chk(sb_e.name, bus_rdata, sb_e.dat);
            end else if (!bus_rvalid) begin
                if (m_rvalid && sb_q.size() > 0) void'(sb_q.pop_front());
                chk("rdata_hold", bus_rdata, m_rdata);
            end
            chk("irq", 32'(irq), 32'(m_irq));
            chk("irq_any", 32'(irq_any), 32'(|m_irq));
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        bus_addr = ADDR_W'(ch * 4 + r); bus_wdata = d; bus_wr = 1'b1;
        step();
        bus_wr = 1'b0;
    endtask

    task automatic rd(input int ch, input int r);
        bus_addr = ADDR_W'(ch * 4 + r); bus_rd = 1'b1;
        step();
        bus_rd = 1'b0;
    endtask

    task automatic rd_exp(input int ch, input int r, input logic [31:0] e);
        ovr = e; ovr_vld = 1;
        rd(ch, r);
        ovr_vld = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; ce = 1'b1; bus_addr = '0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = '0;
        #1;
        step(); step();
        reset = 1'b0;
        chk("reset_rdata", bus_rdata, 32'h0);
        chk("reset_rvalid", 32'(bus_rvalid), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_irq_any", 32'(irq_any), 32'h0);
        mon_on = 1;
        for (int c = 0; c < NT; c++)
            for (int r = 0; r < 4; r++) rd_exp(c, r, 32'h0);

        // Periodic /2, RELOAD=COUNT=3: count holds each value two clocks, underflow every 8
        wr(0, 0, 3); wr(0, 1, 3); wr(0, 2, 32'h11);
        for (int i = 1; i <= 16; i++) begin
            if (i == 9) begin
                wr(0, 3, 1);
            end else begin
                rd_exp(0, 1, 32'(3 - ((i - 1) % 8) / 2));
            end
            if (i == 7)  chk("periodic_irq_before_first", 32'(irq[0]), 32'h0);
            if (i == 8)  chk("periodic_irq_first", 32'(irq[0]), 32'h1);
            if (i == 15) chk("periodic_irq_before_second", 32'(irq[0]), 32'h0);
            if (i == 16) chk("periodic_irq_second", 32'(irq[0]), 32'h1);
        end
        wr(0, 2, 0); wr(0, 3, 1);

        // One-shot: single underflow, enable drops, COUNT reloaded, irq masked
        wr(0, 0, 5); wr(0, 1, 0); wr(0, 2, 32'h09);
        step(); step(); step();
        rd_exp(0, 2, 32'h08);
        rd_exp(0, 1, 32'h5);
        rd_exp(0, 3, 32'h1);
        chk("oneshot_irq_masked", 32'(irq[0]), 32'h0);
        wr(0, 3, 1);

        // W1C colliding with underflow: set wins
        wr(0, 0, 0); wr(0, 1, 0); wr(0, 2, 32'h01);
        step();
        wr(0, 3, 1);
        rd_exp(0, 3, 32'h1);
        wr(0, 2, 0); wr(0, 3, 1);

        // COUNT write colliding with tick: write wins, no reload/underflow
        wr(0, 0, 7); wr(0, 1, 0); wr(0, 2, 32'h01);
        step();
        wr(0, 1, 32'h20);
        rd_exp(0, 1, 32'h20);
        rd_exp(0, 3, 32'h0);
        wr(0, 2, 0);

        // Full-width RELOAD, same-cycle read/write returns old value, upper bits read 0
        wr(2, 0, 32'hFFFF_FFFF);
        rd_exp(2, 0, 32'hFFFF_FFFF);
        bus_addr = ADDR_W'(8); bus_wdata = 32'h1234_5678; bus_wr = 1; bus_rd = 1;
        ovr = 32'hFFFF_FFFF; ovr_vld = 1;
        step();
        bus_wr = 0; bus_rd = 0; ovr_vld = 0;
        rd_exp(2, 0, 32'h1234_5678);
        wr(2, 2, 32'hFFFF_FFFF);
        rd_exp(2, 2, 32'h1F);
        wr(2, 2, 0);
        rd_exp(2, 3, 32'h0);

        // Unmapped channel: writes ignored, reads zero
        wr(3, 0, 32'hDEAD_BEEF);
        rd_exp(3, 0, 32'h0);
        rd_exp(3, 1, 32'h0);

        // Channel 1 interrupt alone
        wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 32'h11);
        step(); step();
        chk("multi_irq_vector", 32'(irq), 32'h2);
        chk("multi_irq_any", 32'(irq_any), 32'h1);
        wr(1, 2, 0);
        chk("irq_masked_by_irq_en", 32'(irq[1]), 32'h0);
        rd_exp(1, 3, 32'h1);
        wr(1, 3, 1);

        // Prescaler /2048 with ce one clock in four
        ce = 0;
        wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 32'h17);
        n = 0;
        for (int i = 1; i <= 9000; i++) begin
            ce = (i % 4 == 0);
            step();
            if (irq[1]) begin
                n = i;
                break;
            end
        end
        chk("presc_2048_clocks", 32'(n), 32'd8192);
        ce = 1;
        wr(1, 2, 0); wr(1, 3, 1);

        // Reset in the middle of a run with ch0 pending
        wr(0, 0, 3); wr(0, 1, 3); wr(0, 2, 32'h11);
        repeat (9) step();
        rd(0, 1);
        reset = 1;
        step();
        reset = 0;
        chk("midreset_rvalid", 32'(bus_rvalid), 32'h0);
        chk("midreset_rdata", bus_rdata, 32'h0);
        chk("midreset_irq", 32'(irq), 32'h0);
        chk("midreset_irq_any", 32'(irq_any), 32'h0);
        for (int r = 0; r < 4; r++) rd_exp(0, r, 32'h0);
        repeat (20) step();
        chk("midreset_no_underflow", 32'(irq), 32'h0);
        rd_exp(0, 3, 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            int op, ch, r;
            logic [31:0] d;
            ce = ($urandom_range(3) != 0);
            op = $urandom_range(3);
            ch = $urandom_range(3);
            r  = $urandom_range(3);
            case (r)
                2:       d = 32'($urandom_range(31));
                3:       d = $urandom;
                default: d = 32'($urandom_range(12));
            endcase
            bus_addr = ADDR_W'(ch * 4 + r);
            bus_wdata = d;
            bus_wr = (op == 1 || op == 3);
            bus_rd = (op == 2 || op == 3);
            step();
            bus_wr = 0; bus_rd = 0;
        end
        ce = 1;
        step(); step();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
